dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the number of consecutive NIC wait cycles before the NIC is forced a grant (legal 1..15).
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, is a synchronous, active-low reset.
REQ-004 Port cpu_memEn, input, 1, is the CPU data-memory access request.
REQ-005 Port cpu_memWrEn, input, 1, selects write (1) or read (0) when cpu_memEn=1.
REQ-006 Port cpu_addr, input, 32, is the CPU access address.
REQ-007 Port cpu_wdata, input, 64, is the CPU write data.
REQ-008 Port cpu_rdata, output, 64, is the CPU read data.
REQ-009 Port cpu_stall, output, 1, is the CPU hold request: the request was not granted this cycle.
REQ-010 Port nic_req, input, 1, is the NIC access request.
REQ-011 Port nic_wr, input, 1, selects write (1) or read (0) for the NIC.
REQ-012 Port nic_addr, input, 32, is the NIC address.
REQ-013 Port nic_wdata, input, 64, is the NIC write data.
REQ-014 Port nic_gnt, output, 1, accepts the NIC request this cycle.
REQ-015 Port nic_rvalid, output, 1, qualifies nic_rdata.
REQ-016 Port nic_rdata, output, 64, is the NIC read data.
REQ-017 Port mem_en, output, 1, is the memory enable.
REQ-018 Port mem_wr_en, output, 1, is the memory write enable.
REQ-019 Port mem_addr, output, 32, is the memory address.
REQ-020 Port mem_wdata, output, 64, is the memory write data.
REQ-021 Port mem_rdata, input, 64, is memory read data, valid one cycle after a read with mem_en=1 and mem_wr_en=0.

Function
REQ-022 Each cycle, at most one requester SHALL be granted; a grant is combinational from the current inputs and the registered state.
REQ-023 Default priority SHALL be CPU: the CPU is granted when cpu_memEn=1, unless the NIC is in a forced grant.
REQ-024 A wait_cnt register (4 bit) SHALL increment in each cycle with nic_req=1 and nic_gnt=0, saturating at STARVE_LIMIT, and SHALL clear to 0 on any NIC grant or when nic_req=0.
REQ-025 When wait_cnt==STARVE_LIMIT and nic_req=1, the NIC SHALL be granted even if cpu_memEn=1 (forced grant).
REQ-026 The NIC SHALL be granted whenever nic_req=1 and cpu_memEn=0.
REQ-027 On a CPU grant: mem_en=1, mem_wr_en=cpu_memWrEn, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_stall=0.
REQ-028 On a NIC grant: mem_en=1, mem_wr_en=nic_wr, mem_addr=nic_addr, mem_wdata=nic_wdata, nic_gnt=1.
REQ-029 cpu_stall SHALL equal cpu_memEn AND NOT CPU-granted; the stalled CPU holds its request, which is re-arbitrated next cycle.
REQ-030 The NIC handshake: a transfer occurs only in a cycle with nic_req=1 and nic_gnt=1; the NIC holds nic_wr, nic_addr and nic_wdata stable until then.
REQ-031 With no grant: mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-032 Registers rd_pend and rd_owner SHALL capture, at each edge, whether a read was granted and to whom (0=CPU, 1=NIC).
REQ-033 With rd_pend=1 and rd_owner=0, cpu_rdata SHALL equal mem_rdata; otherwise cpu_rdata=0.
REQ-034 With rd_pend=1 and rd_owner=1, nic_rvalid=1 and nic_rdata=mem_rdata; otherwise both are 0.
REQ-035 Read latency SHALL be exactly one cycle from grant to data for both requesters; back-to-back reads from alternating owners are legal every cycle.
REQ-036 Writes SHALL NOT set rd_pend.

Reset
REQ-037 While reset=0 at a clock edge: wait_cnt=0, rd_pend=0 and rd_owner=0.
REQ-038 While reset=0, the outputs mem_en, mem_wr_en, nic_gnt, cpu_stall and nic_rvalid SHALL be forced to 0 and all data/address outputs to 0, regardless of the request inputs.
REQ-039 Reset asserted mid-read SHALL discard the pending return: no nic_rvalid and cpu_rdata=0 in the cycle after reset deasserts.

Verification
REQ-040 CPU read only: cpu_memEn=1, cpu_memWrEn=0, cpu_addr=0x40 for 1 cycle, with mem_rdata=0xDEAD next cycle -> mem_en=1, mem_addr=0x40, cpu_stall=0, then cpu_rdata=0xDEAD.
REQ-041 NIC write while the CPU is idle: nic_req=1, nic_wr=1, nic_addr=0x80, nic_wdata=0x1234 -> nic_gnt=1, mem_wr_en=1, mem_wdata=0x1234 in the same cycle, and nic_rvalid stays 0.
REQ-042 Starvation with STARVE_LIMIT=4: cpu_memEn=1 and nic_req=1 held continuously -> CPU granted cycles 0-3, NIC granted in cycle 4 with cpu_stall=1, CPU granted in cycle 5, NIC forced again in cycle 9.
REQ-043 Alternating reads (CPU read 0x10, NIC read 0x20 in consecutive cycles, mem_rdata=0xA then 0xB) -> cpu_rdata=0xA in cycle +1, nic_rvalid=1 with nic_rdata=0xB in cycle +2.
REQ-044 Reset mid-operation: drive reset=0 during a granted NIC read -> all outputs 0 while reset=0, no nic_rvalid afterwards, and wait_cnt restarts from 0.
REQ-045 Idle: no requests for 10 cycles -> mem_en=0, cpu_stall=0, nic_gnt=0 and nic_rvalid=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU has default priority; a NIC kept waiting
// STARVE_LIMIT cycles is forced a grant. Reads return one cycle later.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_memEn,
    input  logic        cpu_memWrEn,
    input  logic [31:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        nic_req,
    input  logic        nic_wr,
    input  logic [31:0] nic_addr,
    input  logic [63:0] nic_wdata,
    output logic        nic_gnt,
    output logic        nic_rvalid,
    output logic [63:0] nic_rdata,
    output logic        mem_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_NIC
    } gnt_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    gnt_e       gnt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nx;
    logic       rd_pend;
    logic       rd_owner;
    logic       nic_force;
    logic       rd_gnt;

    assign nic_force = nic_req && (wait_cnt == LIMIT);

    // A starved NIC beats the CPU; otherwise the NIC only fills idle CPU slots.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            gnt = GNT_NONE;
        end else if (nic_force) begin
            gnt = GNT_NIC;
        end else if (cpu_memEn) begin
            gnt = GNT_CPU;
        end else if (nic_req) begin
            gnt = GNT_NIC;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        nic_gnt   = 1'b0;
        rd_gnt    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                mem_en    = 1'b1;
                mem_wr_en = cpu_memWrEn;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                rd_gnt    = !cpu_memWrEn;
            end
            GNT_NIC: begin
                mem_en    = 1'b1;
                mem_wr_en = nic_wr;
                mem_addr  = nic_addr;
                mem_wdata = nic_wdata;
                nic_gnt   = 1'b1;
                rd_gnt    = !nic_wr;
            end
            default: ;
        endcase
    end

    assign cpu_stall = reset && cpu_memEn && (gnt != GNT_CPU);

    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (!nic_req || nic_gnt) begin
            wait_cnt_nx = '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt_nx = wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            rd_pend  <= rd_gnt;
            rd_owner <= (gnt == GNT_NIC);
        end
    end

    // Return path is gated by reset so a read cut off by reset never surfaces.
    assign cpu_rdata  = (reset && rd_pend && !rd_owner) ? mem_rdata : '0;
    assign nic_rvalid = reset && rd_pend && rd_owner;
    assign nic_rdata  = nic_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single reads/writes,
// starvation forcing, alternating reads, mid-read reset and idle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memEn;
    logic        cpu_memWrEn;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic        nic_req;
    logic        nic_wr;
    logic [31:0] nic_addr;
    logic [63:0] nic_wdata;
    logic        nic_gnt;
    logic        nic_rvalid;
    logic [63:0] nic_rdata;
    logic        mem_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_memEn  (cpu_memEn),
        .cpu_memWrEn(cpu_memWrEn),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .nic_req    (nic_req),
        .nic_wr     (nic_wr),
        .nic_addr   (nic_addr),
        .nic_wdata  (nic_wdata),
        .nic_gnt    (nic_gnt),
        .nic_rvalid (nic_rvalid),
        .nic_rdata  (nic_rdata),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_memEn   = 1'b0;
        cpu_memWrEn = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        nic_req     = 1'b0;
        nic_wr      = 1'b0;
        nic_addr    = '0;
        nic_wdata   = '0;
        mem_rdata   = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        cpu_memEn   = 1'b1;
        cpu_memWrEn = 1'b1;
        cpu_addr    = 32'h44;
        cpu_wdata   = 64'h55;
        nic_req     = 1'b1;
        nic_wr      = 1'b0;
        nic_addr    = 32'h66;
        nic_wdata   = 64'h77;
        mem_rdata   = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if ({mem_en, mem_wr_en, nic_gnt, cpu_stall, nic_rvalid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctl: got %b want 00000",
                         {mem_en, mem_wr_en, nic_gnt, cpu_stall, nic_rvalid});
            end
            checks++;
            if (mem_addr !== 32'h0 || mem_wdata !== 64'h0 ||
                cpu_rdata !== 64'h0 || nic_rdata !== 64'h0) begin
                errors++;
                $display("FAIL reset_data: addr=%h wdata=%h crd=%h nrd=%h want 0",
                         mem_addr, mem_wdata, cpu_rdata, nic_rdata);
            end
        end
        idle_inputs();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        next_cycle();
        idle_inputs();
        cpu_memEn = 1'b1;
        cpu_addr  = 32'h40;
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'h40 ||
            cpu_stall !== 1'b0 || nic_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_gnt: en=%b we=%b addr=%h stall=%b ng=%b want 1 0 40 0 0",
                     mem_en, mem_wr_en, mem_addr, cpu_stall, nic_gnt);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 64'hDEAD;
        #1;
        checks++;
        if (cpu_rdata !== 64'hDEAD || nic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_data: rdata=%h rvalid=%b want dead 0",
                     cpu_rdata, nic_rvalid);
        end
        next_cycle();
        mem_rdata = 64'hDEAD;
        #1;
        checks++;
        if (cpu_rdata !== 64'h0) begin
            errors++;
            $display("FAIL cpu_read_once: rdata=%h want 0", cpu_rdata);
        end
    endtask

    task automatic test_nic_write();
        next_cycle();
        idle_inputs();
        nic_req   = 1'b1;
        nic_wr    = 1'b1;
        nic_addr  = 32'h80;
        nic_wdata = 64'h1234;
        #1;
        checks++;
        if (nic_gnt !== 1'b1 || mem_en !== 1'b1 || mem_wr_en !== 1'b1 ||
            mem_addr !== 32'h80 || mem_wdata !== 64'h1234) begin
            errors++;
            $display("FAIL nic_write: gnt=%b en=%b we=%b addr=%h wd=%h want 1 1 1 80 1234",
                     nic_gnt, mem_en, mem_wr_en, mem_addr, mem_wdata);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 64'h5555;
        #1;
        checks++;
        if (nic_rvalid !== 1'b0 || nic_rdata !== 64'h0 || cpu_rdata !== 64'h0) begin
            errors++;
            $display("FAIL nic_write_norv: rv=%b nrd=%h crd=%h want 0 0 0",
                     nic_rvalid, nic_rdata, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_nic;
        next_cycle();
        idle_inputs();
        cpu_memEn = 1'b1;
        cpu_addr  = 32'h100;
        nic_req   = 1'b1;
        nic_wr    = 1'b1;
        nic_addr  = 32'h200;
        nic_wdata = 64'h77;
        for (int c = 0; c < 11; c++) begin
            if (c != 0) next_cycle();
            #1;
            exp_nic = (c == 4) || (c == 9);
            checks++;
            if (nic_gnt !== exp_nic || cpu_stall !== exp_nic ||
                mem_addr !== (exp_nic ? 32'h200 : 32'h100)) begin
                errors++;
                $display("FAIL starve_c%0d: gnt=%b stall=%b addr=%h want gnt=%b",
                         c, nic_gnt, cpu_stall, mem_addr, exp_nic);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        next_cycle();
        idle_inputs();
        cpu_memEn = 1'b1;
        cpu_addr  = 32'h10;
        #1;
        checks++;
        if (mem_addr !== 32'h10 || cpu_stall !== 1'b0 || nic_gnt !== 1'b0) begin
            errors++;
            $display("FAIL alt_cpu_gnt: addr=%h stall=%b ng=%b want 10 0 0",
                     mem_addr, cpu_stall, nic_gnt);
        end
        next_cycle();
        idle_inputs();
        nic_req   = 1'b1;
        nic_addr  = 32'h20;
        mem_rdata = 64'hA;
        #1;
        checks++;
        if (cpu_rdata !== 64'hA || nic_gnt !== 1'b1 || mem_addr !== 32'h20 ||
            nic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL alt_cpu_data: crd=%h ng=%b addr=%h rv=%b want a 1 20 0",
                     cpu_rdata, nic_gnt, mem_addr, nic_rvalid);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 64'hB;
        #1;
        checks++;
        if (nic_rvalid !== 1'b1 || nic_rdata !== 64'hB || cpu_rdata !== 64'h0) begin
            errors++;
            $display("FAIL alt_nic_data: rv=%b nrd=%h crd=%h want 1 b 0",
                     nic_rvalid, nic_rdata, cpu_rdata);
        end
        next_cycle();
        idle_inputs();
        cpu_memEn   = 1'b1;
        cpu_memWrEn = 1'b1;
        cpu_addr    = 32'h50;
        cpu_wdata   = 64'hCAFE;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wdata !== 64'hCAFE || mem_addr !== 32'h50) begin
            errors++;
            $display("FAIL cpu_write: we=%b wd=%h addr=%h want 1 cafe 50",
                     mem_wr_en, mem_wdata, mem_addr);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 64'h99;
        #1;
        checks++;
        if (cpu_rdata !== 64'h0 || nic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_write_norv: crd=%h rv=%b want 0 0", cpu_rdata, nic_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_nic;
        next_cycle();
        idle_inputs();
        nic_req  = 1'b1;
        nic_addr = 32'h30;
        #1;
        checks++;
        if (nic_gnt !== 1'b1 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_nic_gnt: ng=%b we=%b want 1 0", nic_gnt, mem_wr_en);
        end
        next_cycle();
        reset     = 1'b0;
        cpu_memEn = 1'b1;
        mem_rdata = 64'hBAD;
        #1;
        checks++;
        if (nic_rvalid !== 1'b0 || nic_rdata !== 64'h0 || mem_en !== 1'b0 ||
            nic_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_reset: rv=%b nrd=%h en=%b ng=%b stall=%b want 0",
                     nic_rvalid, nic_rdata, mem_en, nic_gnt, cpu_stall);
        end
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        mem_rdata = 64'hBAD;
        #1;
        checks++;
        if (nic_rvalid !== 1'b0 || cpu_rdata !== 64'h0) begin
            errors++;
            $display("FAIL mid_after_reset: rv=%b crd=%h want 0 0", nic_rvalid, cpu_rdata);
        end
        // Build up wait_cnt to 3, reset, then confirm the count starts over.
        cpu_memEn = 1'b1;
        cpu_addr  = 32'h8;
        nic_req   = 1'b1;
        nic_wr    = 1'b1;
        nic_addr  = 32'h9;
        mem_rdata = '0;
        for (int c = 0; c < 3; c++) next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) next_cycle();
            #1;
            exp_nic = (c == 4);
            checks++;
            if (nic_gnt !== exp_nic || cpu_stall !== exp_nic) begin
                errors++;
                $display("FAIL wait_restart_c%0d: ng=%b stall=%b want %b",
                         c, nic_gnt, cpu_stall, exp_nic);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_idle();
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            if (c != 0) next_cycle();
            mem_rdata = 64'h1111 * (c + 1);
            #1;
            checks++;
            if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || nic_gnt !== 1'b0 ||
                nic_rvalid !== 1'b0 || cpu_rdata !== 64'h0) begin
                errors++;
                $display("FAIL idle_c%0d: en=%b stall=%b ng=%b rv=%b crd=%h want 0",
                         c, mem_en, cpu_stall, nic_gnt, nic_rvalid, cpu_rdata);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_cpu_read();
        test_nic_write();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
